// File: rtl/mmio_pkg.sv
// mmio_pkg: shared decode constants for the mmio_hub peripheral hub.
// Region codes live in addr[31:20]; register words are selected by addr[4:2].
package mmio_pkg;

    typedef logic [11:0] region_t;

    localparam region_t RegionSw     = 12'h001;
    localparam region_t RegionLed    = 12'h002;
    localparam region_t RegionHex    = 12'h003;
    localparam region_t RegionTimer  = 12'h004;
    localparam region_t RegionKbd    = 12'h005;
    localparam region_t RegionStatus = 12'h00F;

    // STATUS bit positions
    localparam int unsigned StInvRead  = 0;
    localparam int unsigned StInvWrite = 1;
    localparam int unsigned StKbdOvf   = 2;
    localparam int unsigned StOccLsb   = 8;

    // Timer i uses word 2i for its count and word 2i+1 for its divisor
    localparam int unsigned TimerCountWord = 0;
    localparam int unsigned TimerDivWord   = 1;
    // A 3-bit word index reaches at most four count/divisor pairs
    localparam int unsigned TimerSlots     = 4;

    typedef enum logic [2:0] {
        TgtNone,
        TgtSw,
        TgtLed,
        TgtHex,
        TgtTimer,
        TgtKbd,
        TgtStatus
    } target_e;

    // Reset divisor for timer idx: max(1, clk_hz / 1000^idx), computed by repeated division
    // so large idx never overflows.
    function automatic logic [31:0] reset_divisor(input int unsigned clk_hz,
                                                  input int unsigned idx);
        int unsigned d;
        d = clk_hz;
        for (int unsigned k = 0; k < idx; k++) begin
            d = d / 1000;
        end
        return (d == 0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: byte FIFO for keyboard input, power-of-two depth.
// Used by mmio_hub only when MMIO_KBD_FIFO_EN is defined. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module kbd_fifo #(
    parameter int unsigned Depth = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrW:0]   count_o
);

    logic [7:0]       mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AddrW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + (AddrW + 1)'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - (AddrW + 1)'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents need no reset since occupancy guards every read
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped hub for switches, LEDs, 7-segment digits, timers, keyboard and a
// sticky status register, with a registered one-cycle read path.
// Build option MMIO_KBD_FIFO_EN: keyboard bytes go through a pop-on-read FIFO with overflow
// and occupancy reporting; otherwise KBD reads return the last byte received.
// Only timers 0..3 are addressable because the word index is addr[4:2].
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 1000000,
    parameter int unsigned NUM_TIMERS = 3,
    parameter int unsigned GPIO_W     = 16,
    parameter int unsigned KBD_DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [GPIO_W-1:0] sw,
    output logic [GPIO_W-1:0] led,
    output logic [31:0]       hex,
    input  logic [7:0]        kbd_ascii,
    input  logic              kbd_valid
);

    localparam int unsigned TimerWords = 2 * NUM_TIMERS;

    region_t           region;
    logic [2:0]        word_idx;
    target_e           tgt;
    logic              inv_rd, inv_wr;
    logic [GPIO_W-1:0] led_q;
    logic [31:0]       hex_q;
    logic [2:0]        st_q, st_d, st_set, st_clr;
    logic [31:0]       rd_val, rdata_q;
    logic              rvalid_q;
    logic [31:0]       cnt_all [TimerSlots];
    logic [31:0]       div_all [TimerSlots];
    logic [31:0]       kbd_rd_val;
    logic [3:0]        kbd_occ;
    logic              kbd_ovf;
    logic              unused_addr;

    assign region      = addr[31:20];
    assign word_idx    = addr[4:2];
    assign unused_addr = ^{addr[19:5], addr[1:0]};

    // Region decode; timer words past the last built timer count as unmapped
    always_comb begin
        tgt = TgtNone;
        case (region)
            RegionSw:     tgt = TgtSw;
            RegionLed:    tgt = TgtLed;
            RegionHex:    tgt = TgtHex;
            RegionTimer:  tgt = (32'(word_idx) < TimerWords) ? TgtTimer : TgtNone;
            RegionKbd:    tgt = TgtKbd;
            RegionStatus: tgt = TgtStatus;
            default:      tgt = TgtNone;
        endcase
    end

    assign inv_rd = re && (tgt == TgtNone);
    // SW and KBD are read-only, so writes there are reported like unmapped writes
    assign inv_wr = we && ((tgt == TgtNone) || (tgt == TgtSw) || (tgt == TgtKbd));

    // LED and HEX output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= '0;
            hex_q <= '0;
        end else if (we) begin
            if (tgt == TgtLed) led_q <= wdata[GPIO_W-1:0];
            if (tgt == TgtHex) hex_q <= wdata;
        end
    end

    for (genvar i = 0; i < TimerSlots; i++) begin : g_timer
        if (i < NUM_TIMERS) begin : g_on
            logic [31:0] cnt_q, cnt_d, div_q, div_d, pre_q, pre_d;
            logic        cnt_wr, div_wr, tick;

            assign cnt_wr = we && (tgt == TgtTimer) && (word_idx == 3'(2 * i + TimerCountWord));
            assign div_wr = we && (tgt == TgtTimer) && (word_idx == 3'(2 * i + TimerDivWord));
            // A divisor write restarts the prescaler, so it never ticks on that cycle
            assign tick   = !div_wr && (div_q != '0) && (pre_q == div_q - 32'd1);

            // Prescaler/count next-state; a count write beats a same-cycle tick
            always_comb begin
                div_d = div_q;
                pre_d = pre_q;
                cnt_d = cnt_q;
                if (div_wr) begin
                    div_d = wdata;
                    pre_d = '0;
                end else if (tick || (div_q == '0)) begin
                    pre_d = '0;
                end else begin
                    pre_d = pre_q + 32'd1;
                end
                if (cnt_wr)    cnt_d = wdata;
                else if (tick) cnt_d = cnt_q + 32'd1;
            end

            // Timer state registers
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q <= '0;
                    pre_q <= '0;
                    div_q <= reset_divisor(CLK_HZ, i);
                end else begin
                    cnt_q <= cnt_d;
                    pre_q <= pre_d;
                    div_q <= div_d;
                end
            end

            assign cnt_all[i] = cnt_q;
            assign div_all[i] = div_q;
        end else begin : g_off
            assign cnt_all[i] = '0;
            assign div_all[i] = '0;
        end
    end

`ifdef MMIO_KBD_FIFO_EN
    logic                       fifo_full, fifo_empty, kbd_pop;
    logic [7:0]                 fifo_head;
    logic [$clog2(KBD_DEPTH):0] fifo_count;

    // Pop only on a KBD read that finds data; an empty read leaves a same-cycle push intact
    assign kbd_pop    = re && (tgt == TgtKbd) && !fifo_empty;
    assign kbd_ovf    = kbd_valid && fifo_full && !kbd_pop;
    assign kbd_rd_val = fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_head};
    assign kbd_occ    = 4'(fifo_count);

    kbd_fifo #(
        .Depth (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (kbd_valid),
        .pop_i   (kbd_pop),
        .wdata_i (kbd_ascii),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
`else
    logic [7:0] kbd_byte_q;
    logic [7:0] unused_kbd_depth;

    assign unused_kbd_depth = 8'(KBD_DEPTH);
    assign kbd_ovf          = 1'b0;
    assign kbd_occ          = '0;
    assign kbd_rd_val       = {24'b0, kbd_byte_q};

    // Last keyboard byte received
    always_ff @(posedge clock) begin
        if (reset)          kbd_byte_q <= '0;
        else if (kbd_valid) kbd_byte_q <= kbd_ascii;
    end
`endif

    // Sticky status: W1C on bits[2:0], a same-cycle set overrides the clear
    always_comb begin
        st_set             = '0;
        st_set[StInvRead]  = inv_rd;
        st_set[StInvWrite] = inv_wr;
        st_set[StKbdOvf]   = kbd_ovf;
        st_clr             = (we && (tgt == TgtStatus)) ? wdata[2:0] : 3'b0;
        st_d               = (st_q & ~st_clr) | st_set;
    end

    // Status register
    always_ff @(posedge clock) begin
        if (reset) st_q <= '0;
        else       st_q <= st_d;
    end

    // Read mux over pre-write state, so a same-cycle write is not visible
    always_comb begin
        rd_val = '0;
        case (tgt)
            TgtSw:     rd_val = 32'(sw);
            TgtLed:    rd_val = 32'(led_q);
            TgtHex:    rd_val = hex_q;
            TgtTimer:  rd_val = word_idx[0] ? div_all[word_idx[2:1]] : cnt_all[word_idx[2:1]];
            TgtKbd:    rd_val = kbd_rd_val;
            TgtStatus: rd_val = 32'(st_q) | (32'(kbd_occ) << StOccLsb);
            default:   rd_val = '0;
        endcase
    end

    // Registered read response; rdata holds between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re;
            if (re) rdata_q <= rd_val;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign led    = led_q;
    assign hex    = hex_q;

endmodule
